// File: rtl/uart_tx.sv
// uart_tx
// Memory-mapped 8N1 UART transmitter for the system bus. Software pushes
// bytes into a small TX FIFO. A bit-level state machine serialises them onto
// the line at a programmable number of clock cycles per bit.
//
// Ports:
//   clk_i          system clock, the only clock of the block
//   rst_ni         synchronous active-low reset
//   uart_req_i     bus request; every request is accepted
//   uart_we_i      write enable
//   uart_be_i      byte enables
//   uart_addr_i    byte address; only bits [9:0] are decoded
//   uart_wdata_i   write data
//   uart_rvalid_o  response valid, one cycle after the request
//   uart_rdata_o   read data (zero for writes and when rvalid is low)
//   uart_err_o     error flag, qualified by rvalid
//   uart_tx_o      serial line, idle high
//   uart_irq_o     level interrupt: enabled, FIFO empty and FSM idle
//
// Register map (offset in bits [9:0]):
//   0x0 TXDATA  W   push wdata[7:0] when be[0]; error if the FIFO is full
//   0x4 STATUS  RO  bit0 full, bit1 empty, bit2 busy, bits[11:8] level
//   0x8 CLKDIV  RW  cycles per bit, byte-writable; zero is stored as one
//   0xC CTRL    RW  bit0 irq_en
module uart_tx #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned FifoDepth    = 8,
  parameter logic [15:0] ClkDivReset  = 16'd434
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    uart_req_i,
  input  logic                    uart_we_i,
  input  logic [3:0]              uart_be_i,
  input  logic [AddressWidth-1:0] uart_addr_i,
  input  logic [DataWidth-1:0]    uart_wdata_i,
  output logic                    uart_rvalid_o,
  output logic [DataWidth-1:0]    uart_rdata_o,
  output logic                    uart_err_o,
  output logic                    uart_tx_o,
  output logic                    uart_irq_o
);

  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  localparam logic [9:0] OFF_TXDATA = 10'h000;
  localparam logic [9:0] OFF_STATUS = 10'h004;
  localparam logic [9:0] OFF_CLKDIV = 10'h008;
  localparam logic [9:0] OFF_CTRL   = 10'h00C;

  localparam logic [CntWidth-1:0] FIFO_FULL_LEVEL = CntWidth'(FifoDepth);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // FIFO storage and bookkeeping
  logic [7:0]          fifo_mem [FifoDepth];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] fifo_count_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [7:0]          fifo_head;

  // Configuration registers
  logic [15:0] clk_div_q;
  logic [15:0] clk_div_d;
  logic [15:0] clk_div_merged;
  logic        irq_en_q;
  logic        irq_en_d;

  // Transmit state machine
  tx_state_e   state_q;
  tx_state_e   state_d;
  logic [15:0] bit_cnt_q;
  logic [15:0] bit_cnt_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        tx_q;
  logic        tx_d;
  logic        busy;
  logic        bit_last;

  // Bus response path
  logic [9:0]           reg_offset;
  logic [DataWidth-1:0] status_word;
  logic [DataWidth-1:0] bus_rdata_d;
  logic                 bus_err_d;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;

  // Address and data bits the register map never looks at.
  logic unused_inputs;
  assign unused_inputs = ^{uart_addr_i[AddressWidth-1:10],
                           uart_wdata_i[DataWidth-1:16],
                           uart_be_i[3:2]};

  assign reg_offset = uart_addr_i[9:0];

  // Full and empty come from the registered count, so a push in the same
  // cycle as a pop from a full FIFO is still refused.
  assign fifo_full  = (fifo_count_q == FIFO_FULL_LEVEL);
  assign fifo_empty = (fifo_count_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  assign busy     = (state_q != IDLE);
  assign bit_last = (bit_cnt_q == 16'd1);

  // The level field is four bits wide, so the count is masked into [11:8].
  assign status_word = ((DataWidth'(fifo_count_q) << 8) & DataWidth'(32'h0000_0F00))
                     | DataWidth'({busy, fifo_empty, fifo_full});

  // Byte-wise merge of a CLKDIV write into the current value.
  assign clk_div_merged = {uart_be_i[1] ? uart_wdata_i[15:8] : clk_div_q[15:8],
                           uart_be_i[0] ? uart_wdata_i[7:0]  : clk_div_q[7:0]};

  // Register decode. Reads return data from state registered in the
  // previous cycle. Unknown offsets give an error and have no side effects.
  always_comb begin
    bus_rdata_d = '0;
    bus_err_d   = 1'b0;
    fifo_push   = 1'b0;
    clk_div_d   = clk_div_q;
    irq_en_d    = irq_en_q;
    if (uart_req_i) begin
      case (reg_offset)
        OFF_TXDATA: begin
          if (uart_we_i && uart_be_i[0]) begin
            if (fifo_full) begin
              bus_err_d = 1'b1;
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
        OFF_STATUS: begin
          if (!uart_we_i) begin
            bus_rdata_d = status_word;
          end
        end
        OFF_CLKDIV: begin
          if (uart_we_i) begin
            clk_div_d = (clk_div_merged == 16'd0) ? 16'd1 : clk_div_merged;
          end else begin
            bus_rdata_d = DataWidth'(clk_div_q);
          end
        end
        OFF_CTRL: begin
          if (uart_we_i) begin
            if (uart_be_i[0]) begin
              irq_en_d = uart_wdata_i[0];
            end
          end else begin
            bus_rdata_d = DataWidth'(irq_en_q);
          end
        end
        default: begin
          bus_err_d = 1'b1;
        end
      endcase
    end
  end

  // One-cycle bus response. Nothing is reported for requests seen in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= uart_req_i;
      rdata_q  <= bus_rdata_d;
      err_q    <= bus_err_d;
    end
  end

  // Configuration registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_div_q <= ClkDivReset;
      irq_en_q  <= 1'b0;
    end else begin
      clk_div_q <= clk_div_d;
      irq_en_q  <= irq_en_d;
    end
  end

  // FIFO pointers and level. Pointers wrap naturally because the depth is a
  // power of two. A simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_q <= fifo_count_q + CntWidth'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CntWidth'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // FIFO storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= uart_wdata_i[7:0];
    end
  end

  // Next-state logic of the transmitter. Each bit period is counted down
  // from CLKDIV, reloaded from the live register at every bit start so a
  // divisor change applies from the next bit. From STOP the next byte is
  // popped straight into START so consecutive frames have no idle gap.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          bit_cnt_d = clk_div_q;
          state_d   = START;
        end
      end
      START: begin
        if (bit_last) begin
          bit_idx_d = 3'd0;
          bit_cnt_d = clk_div_q;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_last) begin
          bit_cnt_d = clk_div_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_last) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            bit_cnt_d = clk_div_q;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The line level is computed from the next state so the pin is driven
    // straight from a flop and cannot glitch.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Transmitter state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= ClkDivReset;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign uart_rvalid_o = rvalid_q;
  assign uart_rdata_o  = rdata_q;
  assign uart_err_o    = err_q;
  assign uart_tx_o     = tx_q;
  assign uart_irq_o    = irq_en_q & fifo_empty & (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Self-checking bench for uart_tx. A frame-level model (byte queue plus a
// per-frame elapsed-cycle counter) predicts the line, interrupt and bus
// response for every cycle. Directed scenarios pin the model with
// hand-computed values; randomized bus traffic exercises the rest.
module tb_uart_tx;

  localparam int Depth = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        uart_req_i = 1'b0;
  logic        uart_we_i = 1'b0;
  logic [3:0]  uart_be_i = 4'b0;
  logic [31:0] uart_addr_i = 32'b0;
  logic [31:0] uart_wdata_i = 32'b0;
  logic        uart_rvalid_o;
  logic [31:0] uart_rdata_o;
  logic        uart_err_o;
  logic        uart_tx_o;
  logic        uart_irq_o;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  longint cyc = 0;

  uart_tx dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .uart_req_i   (uart_req_i),
    .uart_we_i    (uart_we_i),
    .uart_be_i    (uart_be_i),
    .uart_addr_i  (uart_addr_i),
    .uart_wdata_i (uart_wdata_i),
    .uart_rvalid_o(uart_rvalid_o),
    .uart_rdata_o (uart_rdata_o),
    .uart_err_o   (uart_err_o),
    .uart_tx_o    (uart_tx_o),
    .uart_irq_o   (uart_irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Model state: what the block must look like during the current cycle.
  logic [7:0]  mq[$];
  bit          m_valid = 1'b0;
  bit          m_in_frame = 1'b0;
  logic [7:0]  m_byte = 8'h0;
  int          m_elapsed = 0;
  logic [15:0] m_clkdiv = 16'd434;
  bit          m_irq_en = 1'b0;
  logic        exp_rvalid = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;
  logic        exp_tx = 1'b1;
  logic        exp_irq = 1'b0;

  // Scratch variables of the model process.
  int          m_size;
  int          m_pos;
  bit          m_ending;
  bit          m_push;
  logic [31:0] m_status;
  logic [31:0] m_rd;
  bit          m_er;
  logic [15:0] m_div_new;
  bit          m_en_new;

  // Advance the model at each clock edge using the inputs of the cycle that
  // just ended. A frame is ten bit periods of CLKDIV cycles: start, eight
  // data bits LSB first, stop. A new frame begins the cycle after the line
  // is free (idle or last frame cycle) and the queue holds a byte.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (!rst_ni) begin
      mq.delete();
      m_valid    = 1'b1;
      m_in_frame = 1'b0;
      m_elapsed  = 0;
      m_clkdiv   = 16'd434;
      m_irq_en   = 1'b0;
      exp_rvalid = 1'b0;
      exp_rdata  = 32'h0;
      exp_err    = 1'b0;
    end else if (m_valid) begin
      m_size    = mq.size();
      m_ending  = m_in_frame && (m_elapsed == 10 * int'(m_clkdiv) - 1);
      m_status  = (32'(m_size) << 8) | {29'b0, m_in_frame, m_size == 0, m_size == Depth};
      m_push    = 1'b0;
      m_rd      = 32'h0;
      m_er      = 1'b0;
      m_div_new = m_clkdiv;
      m_en_new  = m_irq_en;
      if (uart_req_i) begin
        case (uart_addr_i[9:0])
          10'h000: if (uart_we_i && uart_be_i[0]) begin
                     if (m_size == Depth) m_er = 1'b1;
                     else m_push = 1'b1;
                   end
          10'h004: if (!uart_we_i) m_rd = m_status;
          10'h008: if (uart_we_i) begin
                     if (uart_be_i[0]) m_div_new[7:0] = uart_wdata_i[7:0];
                     if (uart_be_i[1]) m_div_new[15:8] = uart_wdata_i[15:8];
                     if (m_div_new == 16'd0) m_div_new = 16'd1;
                   end else m_rd = {16'h0, m_clkdiv};
          10'h00C: if (uart_we_i) begin
                     if (uart_be_i[0]) m_en_new = uart_wdata_i[0];
                   end else m_rd = {31'h0, m_irq_en};
          default: m_er = 1'b1;
        endcase
      end
      exp_rvalid = uart_req_i;
      exp_rdata  = m_rd;
      exp_err    = m_er;
      if ((!m_in_frame || m_ending) && m_size > 0) begin
        m_byte     = mq.pop_front();
        m_in_frame = 1'b1;
        m_elapsed  = 0;
      end else if (m_ending) begin
        m_in_frame = 1'b0;
      end else if (m_in_frame) begin
        m_elapsed = m_elapsed + 1;
      end
      if (m_push) mq.push_back(uart_wdata_i[7:0]);
      m_clkdiv = m_div_new;
      m_irq_en = m_en_new;
    end
    if (m_in_frame) begin
      m_pos = m_elapsed / int'(m_clkdiv);
      if (m_pos == 0) exp_tx = 1'b0;
      else if (m_pos <= 8) exp_tx = m_byte[m_pos-1];
      else exp_tx = 1'b1;
    end else begin
      exp_tx = 1'b1;
    end
    exp_irq = m_irq_en && (mq.size() == 0) && !m_in_frame;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk_i) begin
    if (m_valid) begin
      checkOutput("tx", {31'b0, uart_tx_o}, {31'b0, exp_tx});
      checkOutput("irq", {31'b0, uart_irq_o}, {31'b0, exp_irq});
      checkOutput("rvalid", {31'b0, uart_rvalid_o}, {31'b0, exp_rvalid});
      checkOutput("rdata", uart_rdata_o, exp_rdata);
      checkOutput("err", {31'b0, uart_err_o}, {31'b0, exp_err});
    end
  end

  always @(negedge clk_i) begin
    if (uart_rvalid_o === 1'b1 && uart_err_o === 1'b1) err_pulses++;
  end

  // Bus drivers: inputs change 2 time units after the rising edge.
  task automatic driveReq(input bit we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
    @(posedge clk_i);
    #2;
    uart_req_i   = 1'b1;
    uart_we_i    = we;
    uart_addr_i  = addr;
    uart_be_i    = be;
    uart_wdata_i = wdata;
  endtask

  task automatic releaseBus();
    @(posedge clk_i);
    #2;
    uart_req_i   = 1'b0;
    uart_we_i    = 1'b0;
    uart_addr_i  = 32'h0;
    uart_be_i    = 4'h0;
    uart_wdata_i = 32'h0;
  endtask

  task automatic applyStimulus(input bit we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata,
                               output logic rv, output logic [31:0] rd,
                               output logic er);
    driveReq(we, addr, be, wdata);
    releaseBus();
    @(negedge clk_i);
    rv = uart_rvalid_o;
    rd = uart_rdata_o;
    er = uart_err_o;
  endtask

  task automatic waitDrain(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!m_in_frame && mq.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk_i);
    end
    checkOutput("drain_done", {31'b0, done}, 32'd1);
    repeat (2) @(posedge clk_i);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic        rv;
  logic [31:0] rd;
  logic        er;
  longint      tw;
  int          lows;
  int          first_irq;
  int          base_err;
  int          op;
  int          gap;
  logic [9:0]  a5_frame = 10'b1101001010;
  logic [31:0] bad_addrs [6] = '{32'h10, 32'h3FC, 32'h2, 32'h1, 32'h200, 32'hFFFF_F004};

  initial begin
    // Reset and register defaults
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    @(negedge clk_i);
    checkOutput("reset_tx", {31'b0, uart_tx_o}, 32'd1);
    checkOutput("reset_irq", {31'b0, uart_irq_o}, 32'd0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    applyStimulus(1'b0, 32'h4, 4'hF, 32'h0, rv, rd, er);
    checkOutput("reset_status", rd, 32'h0000_0002);
    applyStimulus(1'b0, 32'h8, 4'hF, 32'h0, rv, rd, er);
    checkOutput("reset_clkdiv", rd, 32'd434);

    // Single byte 0xA5 at four cycles per bit
    applyStimulus(1'b1, 32'h8, 4'b0011, 32'd4, rv, rd, er);
    driveReq(1'b1, 32'h0, 4'b0001, 32'hA5);
    tw = cyc;
    releaseBus();
    @(negedge clk_i);
    checkOutput("a5_write_rvalid", {31'b0, rv | uart_rvalid_o}, 32'd1);
    checkOutput("a5_write_err", {31'b0, uart_err_o}, 32'd0);
    checkOutput("a5_tx_before_start", {31'b0, uart_tx_o}, 32'd1);
    lows = 0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk_i);
      if (uart_tx_o !== ((k < 40) ? a5_frame[k/4] : 1'b1)) lows++;
    end
    checkOutput("a5_line_pattern_errors", lows, 32'd0);
    driveReq(1'b1, 32'h0, 4'b0001, 32'hA5);
    releaseBus();
    applyStimulus(1'b0, 32'h4, 4'hF, 32'h0, rv, rd, er);
    checkOutput("a5_status_busy", rd, 32'h0000_0006);
    waitDrain(200);

    // FIFO full: nine bytes accepted, the tenth refused
    applyStimulus(1'b1, 32'h8, 4'b0011, 32'd100, rv, rd, er);
    base_err = err_pulses;
    for (int i = 0; i < 10; i++) begin
      driveReq(1'b1, 32'h0, 4'b0001, {24'h0, 8'($urandom)});
    end
    releaseBus();
    @(negedge clk_i);
    checkOutput("overflow_err", {31'b0, uart_err_o}, 32'd1);
    @(negedge clk_i);
    checkOutput("overflow_err_count", err_pulses - base_err, 32'd1);
    applyStimulus(1'b0, 32'h4, 4'hF, 32'h0, rv, rd, er);
    checkOutput("full_status", rd, 32'h0000_0805);
    waitDrain(12000);
    applyStimulus(1'b0, 32'h4, 4'hF, 32'h0, rv, rd, er);
    checkOutput("drained_status", rd, 32'h0000_0002);

    // Interrupt after two back-to-back bytes at two cycles per bit
    applyStimulus(1'b1, 32'hC, 4'b0001, 32'd1, rv, rd, er);
    applyStimulus(1'b1, 32'h8, 4'b0011, 32'd2, rv, rd, er);
    driveReq(1'b1, 32'h0, 4'b0001, 32'h3C);
    tw = cyc;
    driveReq(1'b1, 32'h0, 4'b0001, 32'hC3);
    releaseBus();
    first_irq = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      if (uart_irq_o === 1'b1 && first_irq < 0) first_irq = int'(cyc - tw);
    end
    checkOutput("irq_first_cycle", first_irq, 32'd42);
    applyStimulus(1'b1, 32'hC, 4'b0001, 32'd0, rv, rd, er);

    // Errors and byte enables
    applyStimulus(1'b0, 32'h10, 4'hF, 32'h0, rv, rd, er);
    checkOutput("bad_offset_rvalid", {31'b0, rv}, 32'd1);
    checkOutput("bad_offset_err", {31'b0, er}, 32'd1);
    checkOutput("bad_offset_rdata", rd, 32'd0);
    applyStimulus(1'b1, 32'h0, 4'b0010, 32'h55, rv, rd, er);
    checkOutput("be_no_push_err", {31'b0, er}, 32'd0);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (uart_tx_o !== 1'b1) lows++;
    end
    checkOutput("be_no_frame", lows, 32'd0);
    applyStimulus(1'b1, 32'h8, 4'b0011, 32'd0, rv, rd, er);
    applyStimulus(1'b0, 32'h8, 4'hF, 32'h0, rv, rd, er);
    checkOutput("clkdiv_zero_is_one", rd, 32'd1);

    // Randomized traffic at several divisors
    for (int seg = 0; seg < 3; seg++) begin
      applyStimulus(1'b1, 32'h8, 4'b0011,
                    (seg == 0) ? 32'd1 : (seg == 1) ? 32'd3 : 32'($urandom_range(2, 6)),
                    rv, rd, er);
      for (int n = 0; n < 150; n++) begin
        op = $urandom_range(0, 99);
        if (op < 55) driveReq(1'b1, 32'h0, {3'($urandom), 1'b1}, $urandom);
        else if (op < 65) driveReq(1'b1, 32'h0, 4'($urandom), $urandom);
        else if (op < 80) driveReq(1'b0, 32'h4, 4'hF, $urandom);
        else if (op < 87) driveReq(1'b1, 32'hC, 4'($urandom), $urandom);
        else if (op < 92) driveReq(1'b0, 32'($urandom_range(0, 3)) << 2, 4'hF, 32'h0);
        else driveReq(1'($urandom), bad_addrs[$urandom_range(0, 5)], 4'hF, $urandom);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) releaseBus();
      end
      releaseBus();
      waitDrain(20000);
    end
    applyStimulus(1'b1, 32'hC, 4'b0001, 32'd0, rv, rd, er);

    // Reset during data bit 3 of 0x35 (bit 3 is low)
    applyStimulus(1'b1, 32'h8, 4'b0011, 32'd4, rv, rd, er);
    driveReq(1'b1, 32'h0, 4'b0001, 32'h35);
    tw = cyc;
    driveReq(1'b1, 32'h0, 4'b0001, 32'h81);
    releaseBus();
    repeat (17) @(posedge clk_i);
    #2;
    rst_ni      = 1'b0;
    uart_req_i  = 1'b1;
    uart_we_i   = 1'b0;
    uart_addr_i = 32'h4;
    uart_be_i   = 4'hF;
    @(negedge clk_i);
    checkOutput("bit3_before_reset", {31'b0, uart_tx_o}, 32'd0);
    @(negedge clk_i);
    checkOutput("reset_mid_tx", {31'b0, uart_tx_o}, 32'd1);
    @(posedge clk_i);
    #2;
    rst_ni     = 1'b1;
    uart_req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("no_rvalid_after_reset", {31'b0, uart_rvalid_o}, 32'd0);
    applyStimulus(1'b0, 32'h4, 4'hF, 32'h0, rv, rd, er);
    checkOutput("status_after_reset", rd, 32'h0000_0002);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      if (uart_tx_o !== 1'b1) lows++;
    end
    checkOutput("no_frame_after_reset", lows, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
